// File: rtl/sync_fifo_mem.sv
// Storage for sync_fifo: a DEPTH x WIDTH register array with one synchronous
// write port and one registered read port. Only the read register is reset;
// the array contents are don't-care after reset.
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Capture the incoming word; the array has no reset so it maps onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; a same-edge write is not visible here, so there is no write-to-read bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO. The pointers carry one extra wrap bit so full and empty
// can be told apart when the addresses match. Flags are combinational from the
// registered pointers, so they change in the cycle after the accepting edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_accept;
  logic          rd_accept;

  // Flags come straight from the pointers; the wrap bit distinguishes full from empty.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  end

  // Each request is judged on its own against the flags seen at this edge.
  always_comb begin
    wr_accept = wr_en && !full;
    rd_accept = rd_en && !empty;
  end

  // Pointer advance; wrapping past DEPTH-1 falls out of the modulo-2^PW increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo. A queue-based model tracks what the FIFO
// should hold and what rd_data should show; each test task compares the DUT
// against it (and against literal values where the behaviour is fixed).
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] model_rd;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  // Drive one cycle of requests, let the edge happen, update the model, sample 1ns later.
  task automatic do_cycle(input logic we, input logic [WIDTH-1:0] wd, input logic re);
    bit acc_w;
    bit acc_r;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    acc_w = we && (model_q.size() < DEPTH);
    acc_r = re && (model_q.size() != 0);
    @(posedge clk);
    if (acc_r) model_rd = model_q.pop_front();
    if (acc_w) model_q.push_back(wd);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    model_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
    checks++;
    if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
    checks++;
    if (rd_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rd_data got=%h exp=00", rd_data); end
    rst = 1'b0;
    model_q.delete();
    model_rd = '0;
  endtask

  task automatic test_single();
    do_cycle(1'b1, 8'hA5, 1'b0);
    checks++;
    if (empty !== 1'b0) begin failures++; $display("[TB] FAIL single_empty_after_wr got=%b exp=0", empty); end
    do_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_data !== 8'hA5) begin failures++; $display("[TB] FAIL single_rd_data got=%h exp=a5", rd_data); end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("[TB] FAIL single_empty_after_rd got=%b exp=1", empty); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (full !== 1'b0) begin failures++; $display("[TB] FAIL fill_full_early i=%0d got=%b exp=0", i, full); end
      do_cycle(1'b1, WIDTH'(i), 1'b0);
    end
    checks++;
    if (full !== 1'b1) begin failures++; $display("[TB] FAIL fill_full got=%b exp=1", full); end
    do_cycle(1'b1, 8'hFF, 1'b0);
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      failures++; $display("[TB] FAIL fill_overflow_flags full=%b empty=%b exp full=1 empty=0", full, empty);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (rd_data !== WIDTH'(i)) begin failures++; $display("[TB] FAIL fill_order i=%0d got=%h exp=%h", i, rd_data, WIDTH'(i)); end
    end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("[TB] FAIL fill_drained_empty got=%b exp=1", empty); end
    do_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_data !== 8'h08) begin failures++; $display("[TB] FAIL fill_underflow_rd_data got=%h exp=08", rd_data); end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("[TB] FAIL fill_underflow_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < 10; i++) begin
      v = WIDTH'($urandom);
      do_cycle(1'b1, v, 1'b0);
      do_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (rd_data !== v) begin failures++; $display("[TB] FAIL wrap_data iter=%0d got=%h exp=%h", i, rd_data, v); end
    end
  endtask

  task automatic test_simultaneous();
    logic [WIDTH-1:0] hold;
    // Four entries stored: both operations happen and occupancy stays at four.
    for (int i = 0; i < 4; i++) do_cycle(1'b1, WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, WIDTH'($urandom), 1'b1);
      checks++;
      if (rd_data !== model_rd || full !== 1'b0 || empty !== 1'b0 || model_q.size() != 4) begin
        failures++;
        $display("[TB] FAIL simul_mid i=%0d rd_data=%h exp=%h full=%b empty=%b", i, rd_data, model_rd, full, empty);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (rd_data !== model_rd) begin failures++; $display("[TB] FAIL simul_drain i=%0d got=%h exp=%h", i, rd_data, model_rd); end
    end
    // Empty: only the write happens, rd_data keeps its last value.
    hold = rd_data;
    do_cycle(1'b1, 8'h3C, 1'b1);
    checks++;
    if (empty !== 1'b0 || rd_data !== hold) begin
      failures++; $display("[TB] FAIL simul_empty empty=%b rd_data=%h exp empty=0 rd_data=%h", empty, rd_data, hold);
    end
    do_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_data !== 8'h3C) begin failures++; $display("[TB] FAIL simul_empty_word got=%h exp=3c", rd_data); end
    // Full: only the read happens, the new word is dropped.
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, WIDTH'(8'h40 + i), 1'b0);
    do_cycle(1'b1, 8'hEE, 1'b1);
    checks++;
    if (full !== 1'b0 || rd_data !== 8'h40) begin
      failures++; $display("[TB] FAIL simul_full full=%b rd_data=%h exp full=0 rd_data=40", full, rd_data);
    end
    for (int i = 1; i < DEPTH; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (rd_data !== WIDTH'(8'h40 + i)) begin failures++; $display("[TB] FAIL simul_full_order i=%0d got=%h exp=%h", i, rd_data, WIDTH'(8'h40 + i)); end
    end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("[TB] FAIL simul_full_dropped empty=%b exp=1", empty); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      do_cycle(1'($urandom), WIDTH'($urandom), 1'($urandom));
      checks++;
      if (rd_data !== model_rd || full !== (model_q.size() == DEPTH) || empty !== (model_q.size() == 0)) begin
        failures++;
        $display("[TB] FAIL random i=%0d rd_data=%h exp=%h full=%b exp=%b empty=%b exp=%b", i, rd_data, model_rd,
                 full, (model_q.size() == DEPTH), empty, (model_q.size() == 0));
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) do_cycle(1'b1, WIDTH'(8'h90 + i), 1'b0);
    do_cycle(1'b0, 8'h00, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || rd_data !== 8'h00) begin
      failures++; $display("[TB] FAIL async_reset empty=%b full=%b rd_data=%h exp 1 0 00", empty, full, rd_data);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    model_rd = '0;
    do_cycle(1'b1, 8'h77, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_data !== 8'h77 || empty !== 1'b1) begin
      failures++; $display("[TB] FAIL async_reset_recover rd_data=%h empty=%b exp 77 1", rd_data, empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_simultaneous();
    sync_reset();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
